// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a synchronous single-port 4096x16 memory.
// Latency: ack one cycle after the request is sampled in IDLE; read rvalid one cycle after ack.
// Backpressure: a requester holds req and command fields until its ack; the losing port stays pending.
module mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  // port 0: CPU
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  // port 1: DMA / loader / I-O
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;

  // Latched command: once captured, port inputs are ignored until IDLE again.
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              cmd_port_q, cmd_port_d;

  // Port granted most recently; reset to 1 so port 0 takes the first tie.
  logic              last_grant_q, last_grant_d;

  // Per-port read data holding registers.
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic              any_req;
  logic              win_port;

  // Pick the winning port among the current requesters.
  always_comb begin
    any_req  = p0_req | p1_req;
    win_port = 1'b0;
    if (p0_req && p1_req) begin
      // Tie: fixed priority favours port 0, otherwise the port not served last.
      win_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      // Single requester (or none): port 1 wins only if it is the one asking.
      win_port = p1_req;
    end
  end

  // Next-state, command capture and output decode.
  always_comb begin
    state_d      = state_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_port_d   = cmd_port_q;
    last_grant_d = last_grant_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;

    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = cmd_addr_q;
    mem_wdata    = cmd_wdata_q;
    p0_ack       = 1'b0;
    p1_ack       = 1'b0;
    p0_rvalid    = 1'b0;
    p1_rvalid    = 1'b0;
    p0_rdata     = p0_rdata_q;
    p1_rdata     = p1_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          cmd_port_d   = win_port;
          cmd_we_d     = win_port ? p1_we    : p0_we;
          cmd_addr_d   = win_port ? p1_addr  : p0_addr;
          cmd_wdata_d  = win_port ? p1_wdata : p0_wdata;
          last_grant_d = win_port;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        mem_read  = ~cmd_we_q;
        mem_write = cmd_we_q;
        p0_ack    = ~cmd_port_q;
        p1_ack    = cmd_port_q;
        // Writes complete here; reads need one more cycle for the memory to answer.
        state_d   = cmd_we_q ? IDLE : RESP;
      end

      RESP: begin
        // Memory output is valid this cycle; present it directly and keep a copy.
        if (cmd_port_q) begin
          p1_rvalid  = 1'b1;
          p1_rdata   = mem_rdata;
          p1_rdata_d = mem_rdata;
        end else begin
          p0_rvalid  = 1'b1;
          p0_rdata   = mem_rdata;
          p0_rdata_d = mem_rdata;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; reset kills any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_port_q   <= 1'b0;
      last_grant_q <= 1'b1;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_port_q   <= cmd_port_d;
      last_grant_q <= last_grant_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin and one fixed-priority instance share stimulus,
// each backed by its own synchronous 4096x16 memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        mem_clr;
  logic        inv_en;

  logic        p0_req, p0_we, p1_req, p1_we;
  logic [11:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;

  // round-robin instance outputs
  logic        a_p0_ack, a_p0_rvalid, a_p1_ack, a_p1_rvalid;
  logic [15:0] a_p0_rdata, a_p1_rdata;
  logic        a_mem_read, a_mem_write;
  logic [11:0] a_mem_addr;
  logic [15:0] a_mem_wdata, a_mem_rdata;
  // fixed-priority instance outputs
  logic        b_p0_ack, b_p0_rvalid, b_p1_ack, b_p1_rvalid;
  logic [15:0] b_p0_rdata, b_p1_rdata;
  logic        b_mem_read, b_mem_write;
  logic [11:0] b_mem_addr;
  logic [15:0] b_mem_wdata, b_mem_rdata;

  logic [15:0] mem_a [4096];
  logic [15:0] mem_b [4096];

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(.ADDR_W(12), .DATA_W(16), .FIXED_PRIO(0)) u_dut_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(a_p0_ack), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(a_p1_ack), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.ADDR_W(12), .DATA_W(16), .FIXED_PRIO(1)) u_dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(b_p0_ack), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(b_p1_ack), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory models: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem_a[i] <= 16'h0000;
    end else if (a_mem_write) begin
      mem_a[a_mem_addr] <= a_mem_wdata;
    end
    if (a_mem_read) a_mem_rdata <= mem_a[a_mem_addr];
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem_b[i] <= 16'h0000;
    end else if (b_mem_write) begin
      mem_b[b_mem_addr] <= b_mem_wdata;
    end
    if (b_mem_read) b_mem_rdata <= mem_b[b_mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Mutual exclusion of strobes, acks and rvalids on both instances, every cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      check("exclusive_a", 32'({a_mem_read & a_mem_write, a_p0_ack & a_p1_ack,
                                a_p0_rvalid & a_p1_rvalid}), 32'd0);
      check("exclusive_b", 32'({b_mem_read & b_mem_write, b_p0_ack & b_p1_ack,
                                b_p0_rvalid & b_p1_rvalid}), 32'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction from a single port on the round-robin instance; returns in IDLE.
  task automatic xact(input int port, input logic we, input logic [11:0] addr,
                      input logic [15:0] wd, input logic [15:0] exp_rd);
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
    end
    tick;
    check("ack0", 32'(a_p0_ack), 32'(port == 0));
    check("ack1", 32'(a_p1_ack), 32'(port == 1));
    check("mem_write", 32'(a_mem_write), 32'(we));
    check("mem_read", 32'(a_mem_read), 32'(!we));
    check("mem_addr", 32'(a_mem_addr), 32'(addr));
    if (we) check("mem_wdata", 32'(a_mem_wdata), 32'(wd));
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick;
    if (we) begin
      check("wr_done_mem_write", 32'(a_mem_write), 32'd0);
      check("wr_done_ack", 32'({a_p0_ack, a_p1_ack}), 32'd0);
    end else begin
      check("rvalid0", 32'(a_p0_rvalid), 32'(port == 0));
      check("rvalid1", 32'(a_p1_rvalid), 32'(port == 1));
      check("rdata", 32'((port == 0) ? a_p0_rdata : a_p1_rdata), 32'(exp_rd));
      tick;
      check("rvalid_off", 32'({a_p0_rvalid, a_p1_rvalid}), 32'd0);
      check("rdata_hold", 32'((port == 0) ? a_p0_rdata : a_p1_rdata), 32'(exp_rd));
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_rd0;
    logic [15:0] exp_rd1;
    int          gp;

    rst_n = 1'b0; mem_clr = 1'b1; inv_en = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    tick;
    tick;
    mem_clr = 1'b0;

    // Reset state
    check("rst_ack", 32'({a_p0_ack, a_p1_ack, b_p0_ack, b_p1_ack}), 32'd0);
    check("rst_rvalid", 32'({a_p0_rvalid, a_p1_rvalid}), 32'd0);
    check("rst_strobes", 32'({a_mem_read, a_mem_write}), 32'd0);
    check("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(a_mem_wdata), 32'd0);
    check("rst_p0_rdata", 32'(a_p0_rdata), 32'd0);
    check("rst_p1_rdata", 32'(a_p1_rdata), 32'd0);
    rst_n = 1'b1;
    inv_en = 1'b1;
    tick;

    // Port 0 write then read back
    xact(0, 1'b1, 12'h010, 16'hBEEF, 16'h0000);
    xact(0, 1'b0, 12'h010, 16'h0000, 16'hBEEF);

    // Preload through the arbiter for the later tests
    xact(0, 1'b1, 12'h100, 16'h1111, 16'h0000);
    xact(0, 1'b1, 12'h200, 16'h2222, 16'h0000);
    xact(0, 1'b1, 12'h020, 16'h5A5A, 16'h0000);
    xact(0, 1'b1, 12'h030, 16'hC3C3, 16'h0000);

    // Both ports read continuously from reset: RR alternates, fixed priority always port 0
    do_reset;
    exp_rd0 = 16'h0000;
    exp_rd1 = 16'h0000;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h100;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'h200;
    for (int g = 0; g < 4; g++) begin
      gp = g % 2;
      tick;
      check("rr_ack0", 32'(a_p0_ack), 32'(gp == 0));
      check("rr_ack1", 32'(a_p1_ack), 32'(gp == 1));
      check("fp_ack0", 32'(b_p0_ack), 32'd1);
      check("fp_ack1", 32'(b_p1_ack), 32'd0);
      tick;
      if (gp == 0) exp_rd0 = 16'h1111;
      else         exp_rd1 = 16'h2222;
      check("rr_rvalid0", 32'(a_p0_rvalid), 32'(gp == 0));
      check("rr_rvalid1", 32'(a_p1_rvalid), 32'(gp == 1));
      check("rr_rdata0", 32'(a_p0_rdata), 32'(exp_rd0));
      check("rr_rdata1", 32'(a_p1_rdata), 32'(exp_rd1));
      check("fp_rvalid", 32'({b_p0_rvalid, b_p1_rvalid}), 32'b10);
      check("fp_rdata0", 32'(b_p0_rdata), 32'h1111);
      check("fp_rdata1", 32'(b_p1_rdata), 32'h0000);
      tick;
      check("fp_no_p1_ack_idle", 32'(b_p1_ack), 32'd0);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;

    // Top address passes through unmodified
    xact(1, 1'b1, 12'hFFF, 16'h1234, 16'h0000);
    xact(0, 1'b0, 12'hFFF, 16'h0000, 16'h1234);

    // Address change during ISSUE is ignored
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h020;
    tick;
    check("latch_ack", 32'(a_p0_ack), 32'd1);
    check("latch_addr_a", 32'(a_mem_addr), 32'h020);
    p0_addr = 12'h030;
    p0_req = 1'b0;
    #1;
    check("latch_addr_b", 32'(a_mem_addr), 32'h020);
    tick;
    check("latch_rvalid", 32'(a_p0_rvalid), 32'd1);
    check("latch_rdata", 32'(a_p0_rdata), 32'h5A5A);
    tick;

    // Reset during ISSUE of a port 1 write kills it
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 12'h040; p1_wdata = 16'hAAAA;
    tick;
    check("rst_wr_issue", 32'(a_mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_wr_drop", 32'(a_mem_write), 32'd0);
    check("rst_wr_ack_drop", 32'(a_p1_ack), 32'd0);
    check("rst_wr_addr", 32'(a_mem_addr), 32'd0);
    p1_req = 1'b0;
    tick;
    check("rst_no_rvalid", 32'({a_p0_rvalid, a_p1_rvalid}), 32'd0);
    rst_n = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h040;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'h200;
    tick;
    check("post_rst_tie_ack0", 32'(a_p0_ack), 32'd1);
    check("post_rst_tie_ack1", 32'(a_p1_ack), 32'd0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick;
    check("post_rst_rvalid", 32'(a_p0_rvalid), 32'd1);
    check("post_rst_old_data", 32'(a_p0_rdata), 32'h0000);
    tick;
    tick;

    inv_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
